// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Latches the winning descriptor, drives the master handshake, supervises
// busy with launch/run timeouts and returns a per-requester done/err pulse.
module i2c_master_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned BYTES_SEND_LOG = 2,
   parameter int unsigned BITS_SEND_MAX  = ((2**BYTES_SEND_LOG)-1)<<3,
   parameter int unsigned LAUNCH_TIMEOUT = 64,
   parameter int unsigned RUN_TIMEOUT    = 1000000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ*8-1:0]               req_addr,
   input  logic [NUM_REQ*BYTES_SEND_LOG-1:0]  req_nbytes,
   input  logic [NUM_REQ*BITS_SEND_MAX-1:0]   req_data,
   output logic [NUM_REQ-1:0]                 req_ack,
   output logic [NUM_REQ-1:0]                 done,
   output logic [NUM_REQ-1:0]                 err,
   output logic                               timeout,
   output logic [$clog2(NUM_REQ)-1:0]         owner,
   output logic                               owner_valid,
   output logic                               m_start_request,
   output logic                               m_grant,
   output logic [7:0]                         m_addr,
   output logic [BYTES_SEND_LOG-1:0]          m_nbytes,
   output logic [BITS_SEND_MAX-1:0]           m_data,
   input  logic                               m_busy,
   input  logic                               m_ack_error
);

   localparam int unsigned OW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StLaunch, StRun, StComplete} state_t;

   state_t              state;
   logic [OW-1:0]       rr_ptr;
   logic [31:0]         cnt;
   logic [31:0]         cnt_inc;
   logic [OW-1:0]       win_idx;
   logic                win_found;
   logic [NUM_REQ-1:0]  owner_oh;
   logic [NUM_REQ-1:0]  win_oh;

   // Saturating increment so a stuck counter never wraps back past a limit.
   assign cnt_inc  = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
   assign owner_oh = NUM_REQ'(1) << owner;
   assign win_oh   = NUM_REQ'(1) << win_idx;

   // Round-robin search: first active request at or after rr_ptr, with wrap.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!win_found && req[(32'(rr_ptr) + k) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = OW'((32'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Arbitration FSM; every output is a register written only here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= StIdle;
         rr_ptr          <= '0;
         cnt             <= '0;
         req_ack         <= '0;
         done            <= '0;
         err             <= '0;
         timeout         <= 1'b0;
         owner           <= '0;
         owner_valid     <= 1'b0;
         m_start_request <= 1'b0;
         m_grant         <= 1'b0;
         m_addr          <= '0;
         m_nbytes        <= '0;
         m_data          <= '0;
      end else begin
         // Pulse outputs default low every cycle.
         req_ack <= '0;
         done    <= '0;
         err     <= '0;
         timeout <= 1'b0;
         unique case (state)
            StIdle: begin
               cnt <= '0;
               // An external master user holding busy blocks arbitration.
               if (win_found && !m_busy) begin
                  m_addr          <= req_addr[32'(win_idx)*8 +: 8];
                  m_nbytes        <= req_nbytes[32'(win_idx)*BYTES_SEND_LOG +: BYTES_SEND_LOG];
                  m_data          <= req_data[32'(win_idx)*BITS_SEND_MAX +: BITS_SEND_MAX];
                  owner           <= win_idx;
                  req_ack         <= win_oh;
                  m_start_request <= 1'b1;
                  m_grant         <= 1'b1;
                  owner_valid     <= 1'b1;
                  state           <= StLaunch;
               end
            end
            StLaunch: begin
               if (m_busy) begin
                  m_start_request <= 1'b0;
                  m_grant         <= 1'b0;
                  cnt             <= '0;
                  state           <= StRun;
               end else if (cnt >= 32'(LAUNCH_TIMEOUT - 1)) begin
                  m_start_request <= 1'b0;
                  m_grant         <= 1'b0;
                  done            <= owner_oh;
                  err             <= owner_oh;
                  timeout         <= 1'b1;
                  cnt             <= '0;
                  state           <= StComplete;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            StRun: begin
               if (!m_busy) begin
                  // ack_error is only valid in the cycle busy falls.
                  done    <= owner_oh;
                  err     <= m_ack_error ? owner_oh : '0;
                  timeout <= 1'b0;
                  cnt     <= '0;
                  state   <= StComplete;
               end else if (cnt >= 32'(RUN_TIMEOUT - 1)) begin
                  done    <= owner_oh;
                  err     <= owner_oh;
                  timeout <= 1'b1;
                  cnt     <= '0;
                  state   <= StComplete;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            StComplete: begin
               owner_valid <= 1'b0;
               rr_ptr      <= (32'(owner) == NUM_REQ - 1) ? '0 : owner + OW'(1);
               cnt         <= '0;
               state       <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter (NUM_REQ=4).
module tb_i2c_master_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_addr;
   logic [7:0]  req_nbytes;
   logic [95:0] req_data;
   logic [3:0]  req_ack, done, err;
   logic        timeout;
   logic [1:0]  owner;
   logic        owner_valid, m_start_request, m_grant;
   logic [7:0]  m_addr;
   logic [1:0]  m_nbytes;
   logic [23:0] m_data;
   logic        m_busy, m_ack_error;

   int tests = 0;
   int fails = 0;

   i2c_master_arbiter #(
      .NUM_REQ(4), .BYTES_SEND_LOG(2), .BITS_SEND_MAX(24),
      .LAUNCH_TIMEOUT(64), .RUN_TIMEOUT(1000000)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_nbytes(req_nbytes),
      .req_data(req_data), .req_ack(req_ack), .done(done), .err(err), .timeout(timeout),
      .owner(owner), .owner_valid(owner_valid), .m_start_request(m_start_request),
      .m_grant(m_grant), .m_addr(m_addr), .m_nbytes(m_nbytes), .m_data(m_data),
      .m_busy(m_busy), .m_ack_error(m_ack_error)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; m_busy = 1'b0; m_ack_error = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // Bounded wait for any req_ack; who=-1 when none arrives.
   task automatic wait_ack(output int who, output int cyc);
      who = -1; cyc = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (req_ack != 4'b0) begin
            cyc = c;
            for (int b = 0; b < 4; b++) if (req_ack[b]) who = b;
            break;
         end
      end
   endtask

   // Master model: busy rises dly cycles after start, stays len cycles.
   task automatic master_txn(input int dly, input int len, input logic ae);
      for (int i = 1; i < dly; i++) tick();
      m_busy = 1'b1;
      for (int i = 0; i < len; i++) tick();
      m_busy = 1'b0; m_ack_error = ae;
      tick();
      m_ack_error = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; m_busy = 1'b0; m_ack_error = 1'b0;
      req_addr = {8'h33, 8'h22, 8'h50, 8'h11};
      req_nbytes = 8'b11_10_10_01;
      req_data = {24'h333333, 24'h222222, 24'h00A55A, 24'h111111};
      tick(); tick(); tick();
      tests++;
      if ({req_ack, done, err, timeout} !== 13'b0) begin
         fails++;
         $display("FAIL reset_pulses: got %b required 0", {req_ack, done, err, timeout});
      end
      tests++;
      if ({owner, owner_valid, m_start_request, m_grant} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 0", {owner, owner_valid, m_start_request, m_grant});
      end
      tests++;
      if ({m_addr, m_nbytes, m_data} !== 34'b0) begin
         fails++;
         $display("FAIL reset_desc: got %h required 0", {m_addr, m_nbytes, m_data});
      end
      req = '0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int who, cyc;
      do_reset();
      req = 4'b0010;
      wait_ack(who, cyc);
      tests++;
      if (who !== 1 || cyc !== 1) begin
         fails++; $display("FAIL single_ack: got idx %0d lat %0d required idx 1 lat 1", who, cyc);
      end
      tests++;
      if ({m_start_request, m_grant, owner_valid, owner} !== 5'b111_01) begin
         fails++;
         $display("FAIL single_launch: got %b required 11101", {m_start_request, m_grant, owner_valid, owner});
      end
      tests++;
      if ({m_addr, m_nbytes, m_data} !== {8'h50, 2'd2, 24'h00A55A}) begin
         fails++; $display("FAIL single_desc: got %h/%0d/%h required 50/2/00a55a", m_addr, m_nbytes, m_data);
      end
      req = '0;
      req_addr[15:8] = 8'h77;
      tick();
      m_busy = 1'b1;
      tick();
      tests++;
      if ({m_start_request, m_grant, owner_valid} !== 3'b001) begin
         fails++;
         $display("FAIL single_drop: got %b required 001", {m_start_request, m_grant, owner_valid});
      end
      for (int i = 0; i < 38; i++) tick();
      tests++;
      if (m_addr !== 8'h50) begin
         fails++; $display("FAIL single_hold: got %h required 50", m_addr);
      end
      m_busy = 1'b0;
      tick();
      tests++;
      if ({done, err, timeout} !== 9'b0010_0000_0) begin
         fails++; $display("FAIL single_done: got %b required 001000000", {done, err, timeout});
      end
      tick();
      tests++;
      if ({done, owner_valid} !== 5'b0) begin
         fails++; $display("FAIL single_after: got %b required 0", {done, owner_valid});
      end
      req_addr[15:8] = 8'h50;
      // rr_ptr is now 2, so with 1 and 2 requesting, 2 must win.
      req = 4'b0110;
      wait_ack(who, cyc);
      tests++;
      if (who !== 2) begin
         fails++; $display("FAIL single_rrptr: got %0d required 2", who);
      end
      req = '0;
      master_txn(2, 3, 1'b0);
      tick();
   endtask

   task automatic test_round_robin();
      int who, cyc;
      int exp_idx [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_ack(who, cyc);
         tests++;
         if (who !== exp_idx[i] || cyc !== ((i == 0) ? 1 : 2)) begin
            fails++;
            $display("FAIL rr_order%0d: got idx %0d lat %0d required idx %0d lat %0d",
                     i, who, cyc, exp_idx[i], (i == 0) ? 1 : 2);
         end
         if (who >= 0) req[who] = 1'b0;
         master_txn(2, 4, 1'b0);
         tests++;
         if (done !== (4'b1 << exp_idx[i])) begin
            fails++; $display("FAIL rr_done%0d: got %b required %b", i, done, 4'b1 << exp_idx[i]);
         end
         if (who >= 0) req[who] = 1'b1;
      end
      req = '0;
      wait_ack(who, cyc);
      master_txn(2, 2, 1'b0);
   endtask

   task automatic test_ack_error();
      int who, cyc;
      do_reset();
      req = 4'b1000;
      wait_ack(who, cyc);
      req = '0;
      master_txn(2, 10, 1'b1);
      tests++;
      if ({done, err, timeout} !== 9'b1000_1000_0) begin
         fails++; $display("FAIL ackerr_done: got %b required 100010000", {done, err, timeout});
      end
      tick();
      tests++;
      if (err !== 4'b0) begin
         fails++; $display("FAIL ackerr_pulse: got %b required 0000", err);
      end
   endtask

   task automatic test_launch_timeout();
      int who, cyc;
      do_reset();
      req = 4'b0001;
      wait_ack(who, cyc);
      req = '0;
      for (int i = 0; i < 63; i++) tick();
      tests++;
      if ({m_start_request, m_grant, done} !== 6'b11_0000) begin
         fails++; $display("FAIL launch_hold: got %b required 110000", {m_start_request, m_grant, done});
      end
      tick();
      tests++;
      if ({m_start_request, m_grant, done, err, timeout} !== 11'b00_0001_0001_1) begin
         fails++;
         $display("FAIL launch_timeout: got %b required 00000100011",
                  {m_start_request, m_grant, done, err, timeout});
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int who, cyc;
      int done_cnt = 0;
      do_reset();
      req = 4'b0010;
      wait_ack(who, cyc);
      req = '0;
      master_txn(2, 3, 1'b0);
      tick();
      req = 4'b0100;
      wait_ack(who, cyc);
      req = '0;
      tick();
      m_busy = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({owner, owner_valid, m_start_request, m_grant, m_addr, m_nbytes, m_data} !== 39'b0) begin
         fails++;
         $display("FAIL midrst_async: got owner %0d valid %b addr %h required all 0",
                  owner, owner_valid, m_addr);
      end
      m_busy = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done != 4'b0) done_cnt++;
      end
      tests++;
      if (done_cnt !== 0) begin
         fails++; $display("FAIL midrst_nodone: got %0d required 0", done_cnt);
      end
      req = 4'b0101;
      wait_ack(who, cyc);
      tests++;
      if (who !== 0) begin
         fails++; $display("FAIL midrst_rrptr: got %0d required 0", who);
      end
      req = '0;
      master_txn(2, 2, 1'b0);
   endtask

   task automatic test_withdraw_busy();
      int who, cyc;
      int done_cnt = 0;
      logic [3:0] ack_or = '0;
      do_reset();
      m_busy = 1'b1;
      req = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         ack_or |= req_ack;
      end
      tests++;
      if (ack_or !== 4'b0) begin
         fails++; $display("FAIL busy_block: got %b required 0000", ack_or);
      end
      m_busy = 1'b0;
      tick();
      tests++;
      if (req_ack !== 4'b0010) begin
         fails++; $display("FAIL busy_release: got %b required 0010", req_ack);
      end
      req = '0;
      tick();
      m_busy = 1'b1;
      tick();
      req[2] = 1'b1;
      tick();
      req[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ack_or |= req_ack;
         if (done != 4'b0) done_cnt++;
      end
      m_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         ack_or |= req_ack;
         if (done != 4'b0) done_cnt++;
      end
      tests++;
      if (ack_or !== 4'b0 || done_cnt !== 1) begin
         fails++; $display("FAIL withdraw: got ack %b dones %0d required ack 0000 dones 1", ack_or, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ack_error();
      test_launch_timeout();
      test_reset_mid_run();
      test_withdraw_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
